// File: rtl/xunitf_pkg.sv
// xunitf_pkg: shared widths and SHA-256 bit functions for the xunit_f round unit.
package xunitf_pkg;

    localparam int WORD_W = 32;
    localparam int DLY_W  = 8;

    typedef logic [WORD_W-1:0] word_t;

    // Rotate right; n is always a small non-zero constant here.
    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
    endfunction

    function automatic word_t ch(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj(input word_t a, input word_t b, input word_t c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round (a..h, W, K -> next a..h).
module sha256_round
    import xunitf_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    // Round arithmetic, all sums wrap mod 2^32.
    always_comb begin
        t1  = h_i + big_sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
        t2  = big_sigma0(a_i) + maj(a_i, b_i, c_i);
        a_o = t1 + t2;
        b_o = a_i;
        c_o = b_i;
        d_o = c_i;
        e_o = d_i + t1;
        f_o = e_i;
        g_o = f_i;
        h_o = g_i;
    end

endmodule

// File: rtl/xunit_f.sv
// xunit_f: SHA-256 round unit with programmable start delay; one round per clock
// once started. Optional build macro XUNITF_RUN_CLEAR_EN makes run also zero the
// state registers.
module xunit_f
    import xunitf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  delay0,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic [31:0] in3,
    input  logic [31:0] in4,
    input  logic [31:0] in5,
    input  logic [31:0] in6,
    input  logic [31:0] in7,
    input  logic [31:0] in8,
    input  logic [31:0] in9,
    output logic [31:0] out0,
    output logic [31:0] out1,
    output logic [31:0] out2,
    output logic [31:0] out3,
    output logic [31:0] out4,
    output logic [31:0] out5,
    output logic [31:0] out6,
    output logic [31:0] out7,
    output logic        done
);

    // Index 0 is word a, index 7 is word h.
    logic [7:0][WORD_W-1:0] st_q, st_d;
    logic [7:0][WORD_W-1:0] rin, rout;
    logic [DLY_W-1:0]       cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic                   done_q, done_d;

    // The first round after a start takes its state from the inputs, later ones feed back.
    always_comb begin
        if (first_q) begin
            rin = {in7, in6, in5, in4, in3, in2, in1, in0};
        end else begin
            rin = st_q;
        end
    end

    sha256_round u_round (
        .a_i (rin[0]), .b_i (rin[1]), .c_i (rin[2]), .d_i (rin[3]),
        .e_i (rin[4]), .f_i (rin[5]), .g_i (rin[6]), .h_i (rin[7]),
        .w_i (in8),    .k_i (in9),
        .a_o (rout[0]), .b_o (rout[1]), .c_o (rout[2]), .d_o (rout[3]),
        .e_o (rout[4]), .f_o (rout[5]), .g_o (rout[6]), .h_o (rout[7])
    );

    // Start/delay/round sequencing. done doubles as the "running" flag, so after reset
    // (first and done both clear) no rounds execute.
    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        done_d  = done_q;
        st_d    = st_q;
        if (run) begin
            cnt_d   = delay0;
            first_d = 1'b1;
            done_d  = 1'b0;
`ifdef XUNITF_RUN_CLEAR_EN
            st_d    = '0;
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end else if (first_q) begin
            st_d    = rout;
            first_d = 1'b0;
            done_d  = 1'b1;
        end else if (done_q) begin
            st_d = rout;
        end
    end

    // State, counter and flags; reset returns the unit to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    assign out0 = st_q[0];
    assign out1 = st_q[1];
    assign out2 = st_q[2];
    assign out3 = st_q[3];
    assign out4 = st_q[4];
    assign out5 = st_q[5];
    assign out6 = st_q[6];
    assign out7 = st_q[7];
    assign done = done_q;

endmodule

// File: tb/tb_xunit_f.sv
// tb_xunit_f: directed, table-driven bench for the xunit_f SHA-256 round unit.
module tb_xunit_f;

    typedef logic [7:0][31:0] st_t;   // [0] = a ... [7] = h

    typedef struct {
        logic [31:0] w;
        logic [31:0] k;
        st_t         exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  delay0;
    logic [31:0] in0, in1, in2, in3, in4, in5, in6, in7, in8, in9;
    logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    xunit_f dut (
        .clk(clk), .rst(rst), .run(run), .delay0(delay0),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in5(in5), .in6(in6), .in7(in7), .in8(in8), .in9(in9),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, written independently of the RTL formulation.
    function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic st_t m_round(input st_t s, input logic [31:0] w, input logic [31:0] k);
        logic [31:0] t1, t2, chv, mjv;
        st_t r;
        chv = s[6] ^ (s[4] & (s[5] ^ s[6]));
        mjv = (s[0] & s[1]) | (s[2] & (s[0] | s[1]));
        t1 = s[7] + (m_ror(s[4], 6) ^ m_ror(s[4], 11) ^ m_ror(s[4], 25)) + chv + k + w;
        t2 = (m_ror(s[0], 2) ^ m_ror(s[0], 13) ^ m_ror(s[0], 22)) + mjv;
        r[0] = t1 + t2;
        r[1] = s[0];
        r[2] = s[1];
        r[3] = s[2];
        r[4] = s[3] + t1;
        r[5] = s[4];
        r[6] = s[5];
        r[7] = s[6];
        return r;
    endfunction

    function automatic st_t mk(input logic [31:0] a, b, c, d, e, f, g, h);
        st_t s;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        s[4] = e; s[5] = f; s[6] = g; s[7] = h;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input st_t s);
        in0 = s[0]; in1 = s[1]; in2 = s[2]; in3 = s[3];
        in4 = s[4]; in5 = s[5]; in6 = s[6]; in7 = s[7];
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_done(input string name, input logic exp);
        n_vec++;
        if (done !== exp) begin
            n_err++;
            $display("FAIL %s done got %b expected %b", name, done, exp);
        end
    endtask

    task automatic check_st(input string name, input st_t exp);
        st_t got;
        got = mk(out0, out1, out2, out3, out4, out5, out6, out7);
        for (int i = 0; i < 8; i++)
            check_word($sformatf("%s.out%0d", name, i), got[i], exp[i]);
    endtask

    initial begin
        vec_t        vecs [16];
        logic [31:0] kt [16];
        st_t         iv, t0_lit, t1_lit, s, held, zero_st, alt;
        logic [31:0] w, k;

        kt = '{32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
               32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
               32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
               32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};
        iv     = mk(32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19);
        t0_lit = mk(32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab);
        t1_lit = mk(32'h5a6ad9ad, 32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85,
                    32'h78ce7989, 32'hfa2a4622, 32'h510e527f, 32'h9b05688c);
        zero_st = '0;

        // "abc" padded block: W0 = 61626380, W15 = 0x18, rest zero.
        s = iv;
        for (int i = 0; i < 16; i++) begin
            vecs[i].w   = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
            vecs[i].k   = kt[i];
            s           = m_round(s, vecs[i].w, vecs[i].k);
            vecs[i].exp = s;
        end

        rst = 1'b1; run = 1'b0; delay0 = 8'd0;
        set_in(zero_st); in8 = '0; in9 = '0;
        repeat (2) tick();
        check_st("reset", zero_st);
        check_done("reset", 1'b0);
        rst = 1'b0;

        // Idle: no rounds run without a start even with live inputs.
        set_in(iv); in8 = 32'hdeadbeef; in9 = 32'h01234567;
        repeat (3) tick();
        check_st("idle", zero_st);
        check_done("idle", 1'b0);

        // Single round then feedback round, delay 0, against published trace values.
        run = 1'b1; delay0 = 8'd0;
        tick();
        run = 1'b0;
        check_done("p0", 1'b0);
        check_st("p0", zero_st);
        in8 = 32'h61626380; in9 = 32'h428a2f98;
        tick();
        check_st("round0", t0_lit);
        check_done("round0", 1'b1);
        in8 = 32'h0; in9 = 32'h71374491;
        tick();
        check_st("round1", t1_lit);
        check_done("round1", 1'b1);

        // Restart mid-run, then 16 back-to-back "abc" rounds from the table.
`ifdef XUNITF_RUN_CLEAR_EN
        held = zero_st;
`else
        held = t1_lit;
`endif
        run = 1'b1; delay0 = 8'd0;
        tick();
        run = 1'b0;
        check_st("restart_p0", held);
        check_done("restart_p0", 1'b0);
        for (int i = 0; i < 16; i++) begin
            in8 = vecs[i].w;
            in9 = vecs[i].k;
            tick();
            check_st($sformatf("abc_t%0d", i), vecs[i].exp);
            check_done($sformatf("abc_t%0d", i), 1'b1);
        end

        // Delay of 3: hold through P0..P0+3, first round at P0+4 from fresh inputs.
`ifdef XUNITF_RUN_CLEAR_EN
        held = zero_st;
`else
        held = vecs[15].exp;
`endif
        alt = vecs[7].exp;
        set_in(alt);
        run = 1'b1; delay0 = 8'd3;
        tick();
        run = 1'b0;
        check_st("dly_p0", held);
        check_done("dly_p0", 1'b0);
        for (int j = 1; j <= 3; j++) begin
            in8 = $urandom; in9 = $urandom;
            tick();
            check_st($sformatf("dly_p%0d", j), held);
            check_done($sformatf("dly_p%0d", j), 1'b0);
        end
        w = 32'hcafef00d; k = 32'h0badc0de;
        in8 = w; in9 = k;
        tick();
        check_st("dly_p4", m_round(alt, w, k));
        check_done("dly_p4", 1'b1);

        // run during a pending delay wins and reloads the counter.
        set_in(iv);
        run = 1'b1; delay0 = 8'd5;
        tick();
        run = 1'b0;
        repeat (2) tick();
        check_done("redly_mid", 1'b0);
        run = 1'b1; delay0 = 8'd0;
        tick();
        run = 1'b0;
        in8 = 32'h61626380; in9 = 32'h428a2f98;
        tick();
        check_st("redly_round", t0_lit);
        check_done("redly_round", 1'b1);

        // Asynchronous reset mid-cycle clears everything without waiting for a clock edge.
        in8 = 32'h0; in9 = 32'h71374491;
        tick();
        #3 rst = 1'b1;
        #1;
        check_st("async_rst", zero_st);
        check_done("async_rst", 1'b0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check_st("post_rst_idle", zero_st);
        check_done("post_rst_idle", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
